// File: rtl/traffic_ctrl_timed.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : traffic_ctrl_timed
//  Purpose  : Two-road traffic-light controller (main road / side road with a
//             car sensor) with built-in phase timers and an optional
//             pedestrian all-red walk phase.
//  Options  : define TRAFFIC_CTRL_PED_EN to build the pedestrian walk phase.
//             Without it, ped_req is ignored, walk is held at 0 and state
//             code 4 is treated as an invalid code.
//  Ports    : clk            - clock, rising edge
//             rst            - synchronous reset, active low
//             C              - side-road car present (already synchronised)
//             ped_req        - pedestrian request (pulse or level)
//             MR/MY/MG       - main road red/yellow/green lamps
//             SR/SY/SG       - side road red/yellow/green lamps
//             ST             - high in the first cycle of a newly entered state
//             walk           - pedestrian walk lamp
//             state[2:0]     - current state code
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_ctrl_timed #(
    parameter int LONG_CYC  = 16,
    parameter int SHORT_CYC = 4,
    parameter int WALK_CYC  = 8,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       C,
    input  logic       ped_req,
    output logic       MR,
    output logic       MY,
    output logic       MG,
    output logic       SR,
    output logic       SY,
    output logic       SG,
    output logic       ST,
    output logic       walk,
    output logic [2:0] state
);

    // State encoding
    localparam logic [2:0] c_main_g = 3'd0;
    localparam logic [2:0] c_main_y = 3'd1;
    localparam logic [2:0] c_side_g = 3'd2;
    localparam logic [2:0] c_side_y = 3'd3;
    localparam logic [2:0] c_ped_w  = 3'd4;

    // Terminal timer counts
    localparam logic [CNT_W-1:0] c_long_m1  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_short_m1 = CNT_W'(SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] c_walk_m1  = CNT_W'(WALK_CYC - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] w_tmr_nxt;
    logic             r_st;
    logic             w_change;
    logic             w_ped_pend;

    // ------------------------------------------------------------------------
    // Pedestrian request latch
    // ------------------------------------------------------------------------
`ifdef TRAFFIC_CTRL_PED_EN
    logic r_ped_pend;

    // A request arriving on the very edge that enters PED_W must survive,
    // so the set term has priority over the clear-on-entry term.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ped_pend <= 1'b0;
        end else if (ped_req) begin
            r_ped_pend <= 1'b1;
        end else if (w_change && (w_state_nxt == c_ped_w)) begin
            r_ped_pend <= 1'b0;
        end
    end

    assign w_ped_pend = r_ped_pend;
`else
    logic [CNT_W+3:0] w_unused_ped;

    assign w_ped_pend   = 1'b0;
    assign w_unused_ped = {ped_req, c_walk_m1, c_ped_w};
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_main_g: begin
                if ((r_tmr == c_long_m1) && (C || w_ped_pend)) begin
                    w_state_nxt = c_main_y;
                end
            end
            c_main_y: begin
                if (r_tmr == c_short_m1) begin
                    w_state_nxt = w_ped_pend ? c_ped_w : c_side_g;
                end
            end
            c_side_g: begin
                // Leave at the maximum green, or early once the minimum green
                // has elapsed and no car is waiting any more.
                if ((r_tmr == c_long_m1) || (!C && (r_tmr >= c_short_m1))) begin
                    w_state_nxt = c_side_y;
                end
            end
            c_side_y: begin
                if (r_tmr == c_short_m1) begin
                    w_state_nxt = c_main_g;
                end
            end
`ifdef TRAFFIC_CTRL_PED_EN
            c_ped_w: begin
                if (r_tmr == c_walk_m1) begin
                    w_state_nxt = C ? c_side_g : c_main_g;
                end
            end
`endif
            default: begin
                // Invalid code: recover to MAIN_G; counts as a transition.
                w_state_nxt = c_main_g;
            end
        endcase
    end

    assign w_change = (w_state_nxt != r_state);

    // ------------------------------------------------------------------------
    // Phase timer: clears on a transition, saturates only in MAIN_G (the only
    // state that may hold indefinitely).
    // ------------------------------------------------------------------------
    always_comb begin
        w_tmr_nxt = r_tmr + CNT_W'(1);
        if (w_change) begin
            w_tmr_nxt = '0;
        end else if ((r_state == c_main_g) && (r_tmr == c_long_m1)) begin
            w_tmr_nxt = r_tmr;
        end
    end

    // ------------------------------------------------------------------------
    // State, timer and state-entry strobe registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_main_g;
            r_tmr   <= '0;
            r_st    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_st    <= w_change;
        end
    end

    // ------------------------------------------------------------------------
    // Lamp decode (pure function of the state register). Invalid codes show
    // all-red so that one lamp per road is always lit.
    // ------------------------------------------------------------------------
    always_comb begin
        MR   = 1'b1;
        MY   = 1'b0;
        MG   = 1'b0;
        SR   = 1'b1;
        SY   = 1'b0;
        SG   = 1'b0;
        walk = 1'b0;
        case (r_state)
            c_main_g: begin
                MR = 1'b0;
                MG = 1'b1;
            end
            c_main_y: begin
                MR = 1'b0;
                MY = 1'b1;
            end
            c_side_g: begin
                SR = 1'b0;
                SG = 1'b1;
            end
            c_side_y: begin
                SR = 1'b0;
                SY = 1'b1;
            end
`ifdef TRAFFIC_CTRL_PED_EN
            c_ped_w: begin
                walk = 1'b1;
            end
`endif
            default: begin
                MR = 1'b1;
                SR = 1'b1;
            end
        endcase
    end

    assign ST    = r_st;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_timed.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_traffic_ctrl_timed
//  Purpose  : Directed self-checking bench for traffic_ctrl_timed with the
//             default parameters (LONG 16, SHORT 4, WALK 8). Each scenario
//             walks a table of expected (state, length) phases cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_ctrl_timed;

    logic       clk = 1'b0;
    logic       rst;
    logic       C;
    logic       ped_req;
    logic       MR, MY, MG, SR, SY, SG, ST, walk;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] MAIN_G = 3'd0;
    localparam logic [2:0] MAIN_Y = 3'd1;
    localparam logic [2:0] SIDE_G = 3'd2;
    localparam logic [2:0] SIDE_Y = 3'd3;
    localparam logic [2:0] PED_W  = 3'd4;

    traffic_ctrl_timed #(
        .LONG_CYC  (16),
        .SHORT_CYC (4),
        .WALK_CYC  (8),
        .CNT_W     (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .C       (C),
        .ped_req (ped_req),
        .MR      (MR),
        .MY      (MY),
        .MG      (MG),
        .SR      (SR),
        .SY      (SY),
        .SG      (SG),
        .ST      (ST),
        .walk    (walk),
        .state   (state)
    );

    always #5 clk = ~clk;

    logic [6:0] lamps;
    assign lamps = {MR, MY, MG, SR, SY, SG, walk};

    // Expected {MR,MY,MG,SR,SY,SG,walk} for each state code
    function automatic logic [6:0] exp_lamps(input logic [2:0] s);
        case (s)
            MAIN_G:  return 7'b0011000;
            MAIN_Y:  return 7'b0101000;
            SIDE_G:  return 7'b1000010;
            SIDE_Y:  return 7'b1000100;
            PED_W:   return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    // Inputs change 1 ns after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        C       = 1'b0;
        ped_req = 1'b0;
        do_reset();
        checks++;
        if (state !== MAIN_G) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", state, MAIN_G);
        end
        checks++;
        if (lamps !== 7'b0011000) begin
            errors++;
            $display("FAIL reset_lamps: got %b want %b", lamps, 7'b0011000);
        end
        checks++;
        if (ST !== 1'b0) begin
            errors++;
            $display("FAIL reset_st: got %b want 0", ST);
        end
        checks++;
        if (dut.r_tmr !== 8'd0) begin
            errors++;
            $display("FAIL reset_tmr: got %0d want 0", dut.r_tmr);
        end
        // No car: MAIN_G held for 100 cycles, ST never asserts
        for (int i = 0; i < 100; i++) begin
            checks++;
            if ((state !== MAIN_G) || (ST !== 1'b0) || (lamps !== 7'b0011000)) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got state=%0d st=%b lamps=%b want state=0 st=0 lamps=0011000",
                         i + 1, state, ST, lamps);
            end
            step();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_full_cycle();
        logic [2:0] ps [8];
        int         pn [8];
        logic       exp_st;
        ps[0] = MAIN_G; pn[0] = 16;
        ps[1] = MAIN_Y; pn[1] = 4;
        ps[2] = SIDE_G; pn[2] = 16;
        ps[3] = SIDE_Y; pn[3] = 4;
        ps[4] = MAIN_G; pn[4] = 1;
        C       = 1'b1;
        ped_req = 1'b0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < pn[p]; i++) begin
                exp_st = (i == 0) && (p > 0);
                checks++;
                if ((state !== ps[p]) || (ST !== exp_st) || (lamps !== exp_lamps(ps[p]))) begin
                    errors++;
                    $display("FAIL full_cycle phase %0d cycle %0d: got state=%0d st=%b lamps=%b want state=%0d st=%b lamps=%b",
                             p, i + 1, state, ST, lamps, ps[p], exp_st, exp_lamps(ps[p]));
                end
                step();
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_side_early();
        logic [2:0] ps [8];
        int         pn [8];
        logic       exp_st;
        ps[0] = MAIN_G; pn[0] = 16;
        ps[1] = MAIN_Y; pn[1] = 4;
        ps[2] = SIDE_G; pn[2] = 4;
        ps[3] = SIDE_Y; pn[3] = 4;
        ps[4] = MAIN_G; pn[4] = 6;
        C       = 1'b1;
        ped_req = 1'b0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < pn[p]; i++) begin
                exp_st = (i == 0) && (p > 0);
                checks++;
                if ((state !== ps[p]) || (ST !== exp_st) || (lamps !== exp_lamps(ps[p]))) begin
                    errors++;
                    $display("FAIL side_early phase %0d cycle %0d: got state=%0d st=%b lamps=%b want state=%0d st=%b lamps=%b",
                             p, i + 1, state, ST, lamps, ps[p], exp_st, exp_lamps(ps[p]));
                end
                if ((p == 2) && (i == 0)) C = 1'b0;
                step();
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_mid_reset();
        logic [2:0] ps [8];
        int         pn [8];
        logic       exp_st;
        ps[0] = MAIN_G; pn[0] = 16;
        ps[1] = MAIN_Y; pn[1] = 4;
        ps[2] = SIDE_G; pn[2] = 16;
        ps[3] = SIDE_Y; pn[3] = 2;
        C       = 1'b1;
        ped_req = 1'b0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < pn[p]; i++) begin
                exp_st = (i == 0) && (p > 0);
                checks++;
                if ((state !== ps[p]) || (ST !== exp_st) || (lamps !== exp_lamps(ps[p]))) begin
                    errors++;
                    $display("FAIL mid_reset_pre phase %0d cycle %0d: got state=%0d st=%b want state=%0d st=%b",
                             p, i + 1, state, ST, ps[p], exp_st);
                end
                if ((p == 3) && (i == 1)) rst = 1'b0;
                step();
            end
        end
        rst = 1'b1;
        checks++;
        if (dut.r_tmr !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_tmr: got %0d want 0", dut.r_tmr);
        end
        ps[4] = MAIN_G; pn[4] = 1;
        ps[3] = SIDE_Y; pn[3] = 4;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < pn[p]; i++) begin
                exp_st = (i == 0) && (p > 0);
                checks++;
                if ((state !== ps[p]) || (ST !== exp_st) || (lamps !== exp_lamps(ps[p]))) begin
                    errors++;
                    $display("FAIL mid_reset_post phase %0d cycle %0d: got state=%0d st=%b want state=%0d st=%b",
                             p, i + 1, state, ST, ps[p], exp_st);
                end
                step();
            end
        end
    endtask

`ifdef TRAFFIC_CTRL_PED_EN
    // ------------------------------------------------------------------------
    task automatic test_ped_walk();
        logic [2:0] ps [8];
        int         pn [8];
        logic       exp_st;
        ps[0] = MAIN_G; pn[0] = 16;
        ps[1] = MAIN_Y; pn[1] = 4;
        ps[2] = PED_W;  pn[2] = 8;
        ps[3] = MAIN_G; pn[3] = 20;
        C       = 1'b0;
        ped_req = 1'b0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < pn[p]; i++) begin
                exp_st = (i == 0) && (p > 0);
                checks++;
                if ((state !== ps[p]) || (ST !== exp_st) || (lamps !== exp_lamps(ps[p]))) begin
                    errors++;
                    $display("FAIL ped_walk phase %0d cycle %0d: got state=%0d st=%b lamps=%b want state=%0d st=%b lamps=%b",
                             p, i + 1, state, ST, lamps, ps[p], exp_st, exp_lamps(ps[p]));
                end
                if ((p == 0) && (i == 4)) ped_req = 1'b1;
                if ((p == 0) && (i == 5)) ped_req = 1'b0;
                step();
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [2:0] ps [8];
        int         pn [8];
        logic       exp_st;
        ps[0] = MAIN_G; pn[0] = 16;
        ps[1] = MAIN_Y; pn[1] = 4;
        ps[2] = PED_W;  pn[2] = 8;
        ps[3] = MAIN_G; pn[3] = 16;
        ps[4] = MAIN_Y; pn[4] = 4;
        ps[5] = PED_W;  pn[5] = 8;
        ps[6] = MAIN_G; pn[6] = 1;
        C       = 1'b0;
        ped_req = 1'b0;
        do_reset();
        for (int p = 0; p < 7; p++) begin
            for (int i = 0; i < pn[p]; i++) begin
                exp_st = (i == 0) && (p > 0);
                checks++;
                if ((state !== ps[p]) || (ST !== exp_st) || (lamps !== exp_lamps(ps[p]))) begin
                    errors++;
                    $display("FAIL back_to_back phase %0d cycle %0d: got state=%0d st=%b lamps=%b want state=%0d st=%b lamps=%b",
                             p, i + 1, state, ST, lamps, ps[p], exp_st, exp_lamps(ps[p]));
                end
                if ((p == 0) && (i == 4)) ped_req = 1'b1;
                if ((p == 0) && (i == 5)) ped_req = 1'b0;
                if ((p == 1) && (i == 3)) ped_req = 1'b1;
                if ((p == 2) && (i == 0)) ped_req = 1'b0;
                step();
            end
        end
    endtask
`else
    // ------------------------------------------------------------------------
    task automatic test_ped_disabled();
        C       = 1'b0;
        ped_req = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ((state !== MAIN_G) || (ST !== 1'b0) || (lamps !== 7'b0011000)) begin
                errors++;
                $display("FAIL ped_disabled cycle %0d: got state=%0d st=%b lamps=%b want state=0 st=0 lamps=0011000",
                         i + 1, state, ST, lamps);
            end
            if (i == 4) ped_req = 1'b1;
            if (i == 5) ped_req = 1'b0;
            step();
        end
    endtask
`endif

    // ------------------------------------------------------------------------
    initial begin
        rst     = 1'b0;
        C       = 1'b0;
        ped_req = 1'b0;
        test_reset();
        test_full_cycle();
        test_side_early();
        test_mid_reset();
`ifdef TRAFFIC_CTRL_PED_EN
        test_ped_walk();
        test_back_to_back();
`else
        test_ped_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
